cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_arbiter_rr_picker.sv | 25 ++
 rtl/cdb_arbiter.sv | 75 +++++++
 tb/tb_cdb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: CDB beat type, unit indices and their fixed result latencies
package cdb_arbiter_pkg;
    localparam int ROB_WIDTH = 6;
    typedef enum logic [1:0] {U_ADD_SUB, U_SHIFTER, U_FPU, U_LSU} unit_e;
    localparam int LAT_ADD_SUB = 1;
    localparam int LAT_SHIFTER = 1;
    localparam int LAT_FPU = 2;
    localparam int LAT_LSU = 4;
    // Ordered by unit_e so element j is the latency of unit j
    localparam int LAT_DEFAULT [4] = '{LAT_ADD_SUB, LAT_SHIFTER, LAT_FPU, LAT_LSU};
    typedef struct packed {
        logic valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0] data;
    } cdb_t;
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// cdb_arbiter_rr_picker: first set bit of elig at or after start, wrapping around
module cdb_arbiter_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);
    logic [W-1:0] k;
    // Scan farthest-first so the candidate closest to start is written last
    always_comb begin
        found = 1'b0;
        idx = '0;
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = W'((int'(start) + i) % N);
            if (elig[k]) begin
                found = 1'b1;
                idx = k;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants the CDB round-robin, reserving each result's landing slot
// by unit latency so two results never share a CDB cycle
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_UNIT = 4,
    parameter int MAX_LAT = 4,
    parameter int LAT [N_UNIT] = LAT_DEFAULT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic [N_UNIT-1:0]                  req_valid,
    output logic [N_UNIT-1:0]                  req_ready,
    input  logic [N_UNIT-1:0][ROB_WIDTH-1:0]   result_tag,
    input  logic [N_UNIT-1:0][31:0]            result_data,
    output cdb_t                               cdb
);
    localparam int RW = $clog2(N_UNIT);
    localparam int LW = $clog2(MAX_LAT + 1);
    logic              cur_valid;
    logic [RW-1:0]     cur_owner;
    // Slot MAX_LAT is never written, so it reads as permanently free
    logic [MAX_LAT:1]  pend_valid;
    logic [RW-1:0]     pend_owner [MAX_LAT:1];
    logic [RW-1:0]     rr;
    logic [RW-1:0]     idx;
    logic [N_UNIT-1:0] elig;
    logic              found;
    logic              grant;
    logic [LW-1:0]     gl;
    always_comb begin
        elig = '0;
        for (int j = 0; j < N_UNIT; j++) elig[j] = req_valid[j] && !pend_valid[LAT[j]];
    end
    cdb_arbiter_rr_picker #(.N(N_UNIT), .W(RW)) u_pick (
        .elig  (elig),
        .start (rr),
        .found (found),
        .idx   (idx)
    );
    assign grant = found && !reset && !flush;
    assign req_ready = grant ? N_UNIT'(1) << idx : '0;
    assign gl = LW'(LAT[idx]);
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_valid <= 1'b0;
            pend_valid <= '0;
            rr <= '0;
        end else if (flush) begin
            cur_valid <= 1'b0;
            pend_valid <= '0;
        end else begin
            cur_valid <= pend_valid[1];
            cur_owner <= pend_owner[1];
            for (int k = 1; k < MAX_LAT; k++) begin
                pend_valid[k] <= pend_valid[k+1];
                pend_owner[k] <= pend_owner[k+1];
            end
            pend_valid[MAX_LAT] <= 1'b0;
            // Grant write lands after the shift so it takes priority in its slot
            if (grant) begin
                if (gl == LW'(1)) begin
                    cur_valid <= 1'b1;
                    cur_owner <= idx;
                end else begin
                    pend_valid[gl - 1'b1] <= 1'b1;
                    pend_owner[gl - 1'b1] <= idx;
                end
                rr <= (idx == RW'(N_UNIT - 1)) ? '0 : idx + 1'b1;
            end
        end
    end
    assign cdb = {cur_valid, result_tag[cur_owner], result_data[cur_owner]};
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scenario tasks check grants inline; a scoreboard of expected
// CDB results (pushed at expected grant time) is checked every cycle
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;
    localparam int N = 4;
    localparam int TL [N] = '{1, 1, 2, 4};
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0][ROB_WIDTH-1:0] result_tag;
    logic [N-1:0][31:0] result_data;
    cdb_t cdb;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int hit;
    bit mon_en = 1'b0;
    typedef struct {int due; int owner;} exp_t;
    exp_t q[$];

    cdb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .result_tag  (result_tag),
        .result_data (result_data),
        .cdb         (cdb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [ROB_WIDTH-1:0] tag_of(input int j, input int c);
        return ROB_WIDTH'((j * 17 + c * 5) % 64);
    endfunction
    function automatic logic [31:0] data_of(input int j, input int c);
        return 32'h1000_0000 * (j + 1) + 32'(c);
    endfunction

    // Each unit's result registers carry a cycle-stamped value every cycle
    always_comb begin
        for (int j = 0; j < N; j++) begin
            result_tag[j] = tag_of(j, cyc);
            result_data[j] = data_of(j, cyc);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            hit = -1;
            foreach (q[i]) if (q[i].due == cyc) hit = i;
            checks++;
            if (cdb.valid !== (hit >= 0)) begin
                failures++;
                $display("FAIL cdb_valid cyc=%0d got=%b want=%b", cyc, cdb.valid, hit >= 0);
            end else if (hit >= 0) begin
                checks++;
                if (cdb.tag !== tag_of(q[hit].owner, cyc) || cdb.data !== data_of(q[hit].owner, cyc)) begin
                    failures++;
                    $display("FAIL cdb_payload cyc=%0d got=%h/%h want owner %0d %h/%h", cyc, cdb.tag,
                             cdb.data, q[hit].owner, tag_of(q[hit].owner, cyc), data_of(q[hit].owner, cyc));
                end
            end
            if (hit >= 0) q.delete(hit);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        logic [N-1:0] rv [9] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0};
        logic [N-1:0] ex [9] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
        reset = 1'b1;
        req_valid = 4'hf;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'h0) begin
            failures++;
            $display("FAIL reset_ready got=%b want=0000", req_ready);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            req_valid = rv[i];
            @(negedge clk);
            checks++;
            if (req_ready !== ex[i]) begin
                failures++;
                $display("FAIL single_ready row=%0d got=%b want=%b", i, req_ready, ex[i]);
            end
            for (int j = 0; j < N; j++) if (ex[i][j]) q.push_back('{cyc + TL[j], j});
            tick();
        end
    endtask

    task automatic test_rotate();
        logic [N-1:0] rv [11] = '{4'hf, 4'hf, 4'hf, 4'hf, 4'h7, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0};
        logic [N-1:0] ex [11] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 11; i++) begin
            req_valid = rv[i];
            @(negedge clk);
            checks++;
            if (req_ready !== ex[i]) begin
                failures++;
                $display("FAIL rotate_ready row=%0d got=%b want=%b", i, req_ready, ex[i]);
            end
            for (int j = 0; j < N; j++) if (ex[i][j]) q.push_back('{cyc + TL[j], j});
            tick();
        end
    endtask

    task automatic test_slot_conflict();
        logic [N-1:0] rv [7] = '{4'h8, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
        logic [N-1:0] ex [7] = '{4'h8, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 7; i++) begin
            req_valid = rv[i];
            @(negedge clk);
            checks++;
            if (req_ready !== ex[i]) begin
                failures++;
                $display("FAIL conflict_ready row=%0d got=%b want=%b", i, req_ready, ex[i]);
            end
            for (int j = 0; j < N; j++) if (ex[i][j]) q.push_back('{cyc + TL[j], j});
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            logic [N-1:0] want;
            want = (i >= 8) ? 4'h0 : ((i % 2 == 0) ? 4'h1 : 4'h2);
            req_valid = (i >= 8) ? 4'h0 : 4'h3;
            @(negedge clk);
            checks++;
            if (req_ready !== want) begin
                failures++;
                $display("FAIL b2b_ready row=%0d got=%b want=%b", i, req_ready, want);
            end
            for (int j = 0; j < N; j++) if (want[j]) q.push_back('{cyc + TL[j], j});
            tick();
        end
    endtask

    task automatic test_flush();
        logic [N-1:0] rv [9] = '{4'h8, 4'h4, 4'hf, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic       fl [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        logic [N-1:0] ex [9] = '{4'h8, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 9; i++) begin
            if (i > 0 && fl[i-1]) q.delete();
            req_valid = rv[i];
            flush = fl[i];
            @(negedge clk);
            checks++;
            if (req_ready !== ex[i]) begin
                failures++;
                $display("FAIL flush_ready row=%0d got=%b want=%b", i, req_ready, ex[i]);
            end
            for (int j = 0; j < N; j++) if (ex[i][j]) q.push_back('{cyc + TL[j], j});
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] rv [8] = '{4'h8, 4'h2, 4'hf, 4'hf, 4'hf, 4'h0, 4'h0, 4'h0};
        logic       rs [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        logic [N-1:0] ex [8] = '{4'h8, 4'h2, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && rs[i-1]) q.delete();
            req_valid = rv[i];
            reset = rs[i];
            @(negedge clk);
            checks++;
            if (req_ready !== ex[i]) begin
                failures++;
                $display("FAIL reset_mid_ready row=%0d got=%b want=%b", i, req_ready, ex[i]);
            end
            for (int j = 0; j < N; j++) if (ex[i][j]) q.push_back('{cyc + TL[j], j});
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        tick();
        mon_en = 1'b1;
        test_reset();
        reset_dut();
        test_rotate();
        reset_dut();
        test_slot_conflict();
        reset_dut();
        test_back_to_back();
        reset_dut();
        test_flush();
        reset_dut();
        test_reset_mid();
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d left want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
